// File: rtl/led_drv_pkg.sv
// Shared encodings for the LED status driver: display modes, staging FSM states, LED width.
package led_drv_pkg;

    localparam int LED_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_DIM    = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

endpackage

// File: rtl/led_status_driver_if.sv
// Configuration handshake between the CPU core (master) and the LED driver (slave).
interface led_status_driver_if #(
    parameter int PWM_BITS = 4
);
    import led_drv_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [LED_W-1:0]    wr_data;
    logic [1:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_duty;

    modport master (
        output wr_valid, wr_data, wr_mode, wr_duty,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_mode, wr_duty,
        output wr_ready
    );
endinterface

// File: rtl/led_tick_gen.sv
// Divide-by-HALF tick generator: one-cycle wrap pulse and a phase bit toggling on each wrap.
module led_tick_gen #(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic wrap,
    output logic phase
);
    localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    assign wrap = (cnt == LAST) && !restart;

    // restart wins over a coincident wrap so the new run always starts lit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (restart) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/led_status_driver.sv
// Stages LED configurations from the core and applies them at PWM frame boundaries.
// Optional LED_HEARTBEAT_EN: LEDG[7] becomes a free-running heartbeat.
module led_status_driver
    import led_drv_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int BLINK_HZ = 1,
    parameter int PWM_BITS = 4
) (
    input  logic                 CLOCK_50,
    input  logic                 KEY0,
    led_status_driver_if.slave   wr,
    output logic [LED_W-1:0]     LEDG
);
    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);

    state_e              state;
    logic                ready_q;
    mode_e               sh_mode, act_mode;
    logic [LED_W-1:0]    sh_data, act_data;
    logic [PWM_BITS-1:0] sh_duty, act_duty;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_end, transfer, apply_blink;
    logic                blink_phase, blink_wrap_unused;
    logic [LED_W-1:0]    led_next;

    function automatic logic [LED_W-1:0] map_led(input mode_e m, input logic [LED_W-1:0] d,
                                                 input logic ph, input logic dim_on);
        case (m)
            MODE_STATIC: map_led = d;
            MODE_BLINK:  map_led = ph ? d : '0;
            MODE_DIM:    map_led = dim_on ? d : '0;
            default:     map_led = '0;
        endcase
    endfunction

    assign frame_end   = (pwm_cnt == '1);
    assign transfer    = wr.wr_valid && ready_q;
    assign apply_blink = (state == ST_PENDING) && frame_end && (sh_mode == MODE_BLINK);
    assign wr.wr_ready = ready_q;

    // A capture in EMPTY never applies in the same cycle, even on a frame end
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state    <= ST_EMPTY;
            ready_q  <= 1'b1;
            sh_mode  <= MODE_OFF;
            sh_data  <= '0;
            sh_duty  <= '0;
            act_mode <= MODE_OFF;
            act_data <= '0;
            act_duty <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (transfer) begin
                        sh_mode <= mode_e'(wr.wr_mode);
                        sh_data <= wr.wr_data;
                        sh_duty <= wr.wr_duty;
                        state   <= ST_PENDING;
                        ready_q <= 1'b0;
                    end
                end
                ST_PENDING: begin
                    if (frame_end) begin
                        act_mode <= sh_mode;
                        act_data <= sh_data;
                        act_duty <= sh_duty;
                        state    <= ST_EMPTY;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) pwm_cnt <= '0;
        else       pwm_cnt <= pwm_cnt + 1'b1;
    end

    led_tick_gen #(.HALF(HALF)) u_blink (
        .clk     (CLOCK_50),
        .rst_n   (KEY0),
        .restart (apply_blink),
        .wrap    (blink_wrap_unused),
        .phase   (blink_phase)
    );

`ifdef LED_HEARTBEAT_EN
    logic hb_phase, hb_wrap_unused;

    led_tick_gen #(.HALF(HALF)) u_heartbeat (
        .clk     (CLOCK_50),
        .rst_n   (KEY0),
        .restart (1'b0),
        .wrap    (hb_wrap_unused),
        .phase   (hb_phase)
    );
`endif

    always_comb begin
        led_next = map_led(act_mode, act_data, blink_phase, pwm_cnt < act_duty);
`ifdef LED_HEARTBEAT_EN
        led_next[LED_W-1] = hb_phase;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) LEDG <= '0;
        else       LEDG <= led_next;
    end
endmodule

// File: tb/tb_led_status_driver.sv
// Randomized self-checking bench for led_status_driver against a time-indexed reference model.
module tb_led_status_driver;
    import led_drv_pkg::*;

    localparam int CLK_HZ = 20, BLINK_HZ = 1, PWM_BITS = 2;
    localparam int HALF = 10, FRAME = 4;
`ifdef LED_HEARTBEAT_EN
    localparam logic [7:0] MASK = 8'h7F;
`else
    localparam logic [7:0] MASK = 8'hFF;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       KEY0;
    logic [7:0] LEDG;

    led_status_driver_if #(.PWM_BITS(PWM_BITS)) wr_if ();

    led_status_driver #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ), .PWM_BITS(PWM_BITS)) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY0     (KEY0),
        .wr       (wr_if),
        .LEDG     (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0, n_pass = 0;

    // Model: cycle index since reset release, restart time of the blink run, staged/active config
    int         m_t, m_rst_t, sh_u, act_u;
    bit         m_pend, m_ready;
    logic [7:0] sh_d, act_d, m_led;
    logic [1:0] sh_m, act_m;

    task automatic model_reset();
        m_t = 0; m_rst_t = 0; m_pend = 0; m_ready = 1;
        sh_d = 0; act_d = 0; sh_m = 0; act_m = 0; sh_u = 0; act_u = 0; m_led = 0;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] m, input int u);
        wr_if.wr_valid = v;
        wr_if.wr_data  = d;
        wr_if.wr_mode  = m;
        wr_if.wr_duty  = PWM_BITS'(u);
    endtask

    task automatic step();
        int         pwm;
        bit         ph, hb;
        logic [7:0] nl;
        @(posedge CLOCK_50);
        if (KEY0) begin
            pwm = m_t % FRAME;
            ph  = (((m_t - m_rst_t) / HALF) % 2) == 0;
            hb  = ((m_t / HALF) % 2) == 0;
            case (act_m)
                2'd0:    nl = 8'h00;
                2'd1:    nl = act_d;
                2'd2:    nl = ph ? act_d : 8'h00;
                default: nl = (pwm < act_u) ? act_d : 8'h00;
            endcase
`ifdef LED_HEARTBEAT_EN
            nl[7] = hb;
`else
            if (hb) nl = nl;
`endif
            if (m_pend && pwm == FRAME - 1) begin
                act_d = sh_d; act_m = sh_m; act_u = sh_u; m_pend = 0;
                if (sh_m == 2'd2) m_rst_t = m_t + 1;
            end else if (wr_if.wr_valid && !m_pend) begin
                sh_d = wr_if.wr_data; sh_m = wr_if.wr_mode; sh_u = int'(wr_if.wr_duty); m_pend = 1;
            end
            m_led   = nl;
            m_ready = !m_pend;
            m_t++;
        end
        #1;
    endtask

    task automatic test_reset();
        KEY0 = 1'b1;
        drive(0, 8'h00, 2'd0, 0);
        #2 KEY0 = 1'b0;
        model_reset();
        repeat (3) begin
            step();
            n_checks++;
            if (LEDG !== 8'h00 || wr_if.wr_ready !== 1'b1)
                $display("FAIL reset_hold LEDG=%h ready=%b expected LEDG=00 ready=1", LEDG, wr_if.wr_ready);
            else n_pass++;
        end
        KEY0 = 1'b1;
        model_reset();
        step();
        n_checks++;
        if (LEDG !== 8'h00 || wr_if.wr_ready !== 1'b1)
            $display("FAIL reset_release LEDG=%h ready=%b expected LEDG=00 ready=1", LEDG, wr_if.wr_ready);
        else n_pass++;
    endtask

    task automatic test_static();
        int         lo;
        logic [7:0] obs [8];
        for (int i = 0; i < FRAME && (m_t % FRAME) != 0; i++) step();
        drive(1, 8'hA5, 2'd1, $urandom_range(0, 3));
        step();
        drive(0, 8'h00, 2'd0, 0);
        lo = (wr_if.wr_ready == 1'b0) ? 1 : 0;
        obs[0] = LEDG;
        for (int k = 1; k < 8; k++) begin
            step();
            if (wr_if.wr_ready == 1'b0) lo++;
            obs[k] = LEDG;
            n_checks++;
            if (LEDG !== m_led || wr_if.wr_ready !== m_ready)
                $display("FAIL static_cyc k=%0d LEDG=%h ready=%b expected %h %b", k, LEDG, wr_if.wr_ready, m_led, m_ready);
            else n_pass++;
        end
        n_checks++;
        if (lo != 3) $display("FAIL static_ready_low got %0d cycles expected 3", lo);
        else n_pass++;
        n_checks++;
        if ((obs[3] & MASK) !== 8'h00) $display("FAIL static_early LEDG=%h expected 00", obs[3]);
        else n_pass++;
        for (int k = 4; k < 8; k++) begin
            n_checks++;
            if ((obs[k] & MASK) !== (8'hA5 & MASK))
                $display("FAIL static_applied k=%0d LEDG=%h expected A5", k, obs[k]);
            else n_pass++;
        end
    endtask

    task automatic test_blink();
        bit         found;
        int         run;
        logic [7:0] cur, want;
        repeat ($urandom_range(0, 3)) step();
        drive(1, 8'h0F, 2'd2, 0);
        step();
        drive(0, 8'h00, 2'd0, 0);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            n_checks++;
            if (LEDG !== m_led) $display("FAIL blink_wait LEDG=%h expected %h", LEDG, m_led);
            else n_pass++;
            if ((LEDG & MASK) == 8'h0F) found = 1;
        end
        n_checks++;
        if (!found) $display("FAIL blink_start LEDG=%h expected 0F within 10 cycles", LEDG);
        else n_pass++;
        want = 8'h0F;
        for (int r = 0; r < 3; r++) begin
            cur = LEDG & MASK;
            run = 1;
            for (int i = 0; i < 15 && (LEDG & MASK) == cur; i++) begin
                step();
                n_checks++;
                if (LEDG !== m_led) $display("FAIL blink_cyc LEDG=%h expected %h", LEDG, m_led);
                else n_pass++;
                if ((LEDG & MASK) == cur) run++;
            end
            n_checks++;
            if (cur !== want || run != HALF)
                $display("FAIL blink_run r=%0d value=%h len=%0d expected value=%h len=%0d", r, cur, run, want, HALF);
            else n_pass++;
            want = (want == 8'h0F) ? 8'h00 : 8'h0F;
        end
    endtask

    task automatic test_dim();
        int on_cnt;
        for (int duty = 1; duty >= 0; duty--) begin
            drive(1, 8'hFF, 2'd3, duty);
            step();
            drive(0, 8'h00, 2'd0, 0);
            repeat (6) step();
            on_cnt = 0;
            repeat (8) begin
                step();
                if ((LEDG & MASK) == (8'hFF & MASK)) on_cnt++;
                n_checks++;
                if (LEDG !== m_led || ((LEDG & MASK) != 8'h00 && (LEDG & MASK) != (8'hFF & MASK)))
                    $display("FAIL dim_cyc duty=%0d LEDG=%h expected %h", duty, LEDG, m_led);
                else n_pass++;
            end
            n_checks++;
            if (on_cnt != 2 * duty) $display("FAIL dim_on_count duty=%0d got %0d expected %0d", duty, on_cnt, 2 * duty);
            else n_pass++;
        end
    endtask

    task automatic test_coincidence();
        int         lat, lo;
        logic [7:0] d;
        d = {1'b0, 7'($urandom)} | 8'h01;
        for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) step();
        drive(1, d, 2'd1, 0);
        step();
        drive(0, 8'h00, 2'd0, 0);
        lat = 0; lo = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (wr_if.wr_ready == 1'b0) lo++;
            step();
            n_checks++;
            if (LEDG !== m_led) $display("FAIL coinc_cyc LEDG=%h expected %h", LEDG, m_led);
            else n_pass++;
            if ((LEDG & MASK) == (d & MASK)) lat = i;
        end
        n_checks++;
        if (lat != FRAME + 1) $display("FAIL coinc_latency got %0d expected %0d", lat, FRAME + 1);
        else n_pass++;
        n_checks++;
        if (lo != FRAME) $display("FAIL coinc_ready_low got %0d expected %0d", lo, FRAME);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         caps;
        logic [7:0] d1;
        d1 = 8'h5A ^ 8'($urandom_range(0, 15));
        repeat ($urandom_range(0, 3)) step();
        drive(1, d1, 2'd1, 0);
        caps = 0;
        for (int i = 0; i < 8 && (caps == 0 || wr_if.wr_ready == 1'b0); i++) begin
            if (wr_if.wr_ready) caps++;
            step();
            drive(1, ~d1, 2'($urandom_range(0, 3)), 1);
        end
        drive(0, 8'h00, 2'd0, 0);
        n_checks++;
        if (caps != 1) $display("FAIL bp_captures got %0d expected 1", caps);
        else n_pass++;
        repeat (6) begin
            step();
            n_checks++;
            if ((LEDG & MASK) !== (d1 & MASK) || LEDG !== m_led)
                $display("FAIL bp_data LEDG=%h expected %h", LEDG, d1);
            else n_pass++;
        end
    endtask

    task automatic test_reset_pending();
        drive(1, 8'h3C, 2'd1, 0);
        step();
        drive(0, 8'h00, 2'd0, 0);
        #2 KEY0 = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (LEDG !== 8'h00 || wr_if.wr_ready !== 1'b1)
            $display("FAIL rstpend_immediate LEDG=%h ready=%b expected 00 1", LEDG, wr_if.wr_ready);
        else n_pass++;
        repeat (2) step();
        KEY0 = 1'b1;
        model_reset();
        repeat (12) begin
            step();
            n_checks++;
            if ((LEDG & MASK) === (8'h3C & MASK) || LEDG !== m_led)
                $display("FAIL rstpend_after LEDG=%h expected %h", LEDG, m_led);
            else n_pass++;
        end
    endtask

`ifdef LED_HEARTBEAT_EN
    task automatic test_heartbeat();
        int         run;
        logic [7:0] cur;
        drive(1, 8'hFF, 2'd0, 0);
        step();
        drive(0, 8'h00, 2'd0, 0);
        repeat (6) step();
        cur = LEDG;
        for (int i = 0; i < 12 && LEDG == cur; i++) step();
        for (int r = 0; r < 2; r++) begin
            cur = LEDG;
            run = 1;
            for (int i = 0; i < 15 && LEDG == cur; i++) begin
                step();
                if (LEDG == cur) run++;
            end
            n_checks++;
            if ((cur !== 8'h80 && cur !== 8'h00) || run != HALF)
                $display("FAIL heartbeat_run value=%h len=%0d expected 80/00 len=%0d", cur, run, HALF);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        for (int w = 0; w < 20; w++) begin
            repeat ($urandom_range(0, 5)) begin
                step();
                n_checks++;
                if (LEDG !== m_led || wr_if.wr_ready !== m_ready)
                    $display("FAIL rand_idle t=%0d LEDG=%h ready=%b expected %h %b", m_t, LEDG, wr_if.wr_ready, m_led, m_ready);
                else n_pass++;
            end
            repeat ($urandom_range(1, 6)) begin
                drive(1, 8'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
                step();
                n_checks++;
                if (LEDG !== m_led || wr_if.wr_ready !== m_ready)
                    $display("FAIL rand_wr t=%0d LEDG=%h ready=%b expected %h %b", m_t, LEDG, wr_if.wr_ready, m_led, m_ready);
                else n_pass++;
            end
            drive(0, 8'h00, 2'd0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_dim();
        test_coincidence();
        test_back_to_back();
        test_reset_pending();
`ifdef LED_HEARTBEAT_EN
        test_heartbeat();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
